// File: rtl/checkpoint_pkg.sv
// Shared types and constants for the checkpoint memory save/restore engine.
package checkpoint_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5,
        ST_HOLD    = 3'd6
    } engine_state_e;

    typedef enum logic {
        DIR_SAVE    = 1'b0,
        DIR_RESTORE = 1'b1
    } dir_e;

    // Byte count rounded up to whole words; the 33-bit add keeps the carry.
    function automatic logic [29:0] calc_words(input logic [31:0] size_bytes);
        logic [32:0] sum;
        sum = {1'b0, size_bytes} + 33'd7;
        return sum[32:3];
    endfunction

    // Clears the byte-offset bits so every address is word aligned.
    function automatic logic [63:0] align_word_addr(input logic [63:0] addr);
        return addr & ~64'h7;
    endfunction

endpackage

// File: rtl/checkpoint_mem_engine_if.sv
// Word read/write memory port between the engine (master) and memory (slave).
interface checkpoint_mem_engine_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [63:0]           rd_addr;
    logic                  rd_resp_valid;
    logic [DATA_WIDTH-1:0] rd_resp_data;
    logic                  rd_resp_err;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [63:0]           wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, rd_resp_valid, rd_resp_data, rd_resp_err, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, rd_resp_valid, rd_resp_data, rd_resp_err, wr_ready
    );
endinterface

// File: rtl/ckpt_xfer_watchdog.sv
// Counts stalled cycles while a transfer waits on memory and flags a timeout.
module ckpt_xfer_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Restart on any handshake or when idle, otherwise count one more stalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The cycle that would complete the budget raises timeout so the FSM leaves on that edge.
    always_comb begin
        timeout = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/checkpoint_mem_engine.sv
// Copies a checkpoint region word by word between live and backing memory,
// one read then one posted write per word, with a running checksum.
module checkpoint_mem_engine
    import checkpoint_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] live_base_addr,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [63:0] save_addr,
    input  logic [63:0] restore_addr,
    input  logic [31:0] transfer_size,
    output logic        save_done,
    output logic        restore_done,
    output logic        xfer_error,
    output logic        busy,
    output logic [31:0] xfer_checksum,
    checkpoint_mem_engine_if.master mem
);
    engine_state_e         state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [63:0]           src_ptr_q, src_ptr_d;
    logic [63:0]           dst_ptr_q, dst_ptr_d;
    logic [29:0]           words_q, words_d;
    logic [29:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           checksum_q, checksum_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  save_done_q, save_done_d;
    logic                  restore_done_q, restore_done_d;
    logic                  xfer_error_q, xfer_error_d;
    logic                  busy_q, busy_d;

    logic rd_hs;
    logic resp_hs;
    logic wr_hs;
    logic active_req;
    logic start_xfer;
    logic wd_en;
    logic wd_clr;
    logic wd_timeout;

    // Handshake decode and watchdog controls from the registered state.
    always_comb begin
        rd_hs      = rd_valid_q && mem.rd_ready;
        resp_hs    = (state_q == ST_RD_WAIT) && mem.rd_resp_valid;
        wr_hs      = wr_valid_q && mem.wr_ready;
        active_req = (dir_q == DIR_SAVE) ? save_req : restore_req;
        wd_en      = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT) || (state_q == ST_WR);
        wd_clr     = rd_hs || resp_hs || wr_hs;
    end

    ckpt_xfer_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (wd_en),
        .clr    (wd_clr),
        .timeout(wd_timeout)
    );

    // Next-state and datapath; every output is derived from the next state so it leaves a flop.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        words_d    = words_q;
        idx_d      = idx_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        start_xfer = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (save_req) begin
                    dir_d      = DIR_SAVE;
                    src_ptr_d  = align_word_addr(live_base_addr);
                    dst_ptr_d  = align_word_addr(save_addr);
                    start_xfer = 1'b1;
                end else if (restore_req) begin
                    dir_d      = DIR_RESTORE;
                    src_ptr_d  = align_word_addr(restore_addr);
                    dst_ptr_d  = align_word_addr(live_base_addr);
                    start_xfer = 1'b1;
                end
                if (start_xfer) begin
                    idx_d      = '0;
                    checksum_d = '0;
                    words_d    = calc_words(transfer_size);
                    state_d    = (words_d == 30'd0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (rd_hs) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem.rd_resp_valid) begin
                    if (mem.rd_resp_err) begin
                        state_d = ST_ERR;
                    end else begin
                        data_d     = mem.rd_resp_data;
                        checksum_d = checksum_q + mem.rd_resp_data[31:0] + mem.rd_resp_data[63:32];
                        state_d    = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (wr_hs) begin
                    idx_d     = idx_q + 30'd1;
                    src_ptr_d = src_ptr_q + 64'(BYTES_PER_WORD);
                    dst_ptr_d = dst_ptr_q + 64'(BYTES_PER_WORD);
                    if (idx_d == words_q) begin
                        state_d = ST_DONE;
                    end else if (!active_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_ERR: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!save_req && !restore_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wd_timeout) begin
            state_d = ST_ERR;
        end

        rd_valid_d     = (state_d == ST_RD_REQ);
        wr_valid_d     = (state_d == ST_WR);
        save_done_d    = (state_d == ST_DONE) && (dir_d == DIR_SAVE);
        restore_done_d = (state_d == ST_DONE) && (dir_d == DIR_RESTORE);
        xfer_error_d   = (state_d == ST_ERR);
        busy_d         = (state_d != ST_IDLE);
    end

    // Engine state, datapath and registered outputs; reset abandons any transfer silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            dir_q          <= DIR_SAVE;
            src_ptr_q      <= '0;
            dst_ptr_q      <= '0;
            words_q        <= '0;
            idx_q          <= '0;
            data_q         <= '0;
            checksum_q     <= '0;
            rd_valid_q     <= 1'b0;
            wr_valid_q     <= 1'b0;
            save_done_q    <= 1'b0;
            restore_done_q <= 1'b0;
            xfer_error_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            src_ptr_q      <= src_ptr_d;
            dst_ptr_q      <= dst_ptr_d;
            words_q        <= words_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            checksum_q     <= checksum_d;
            rd_valid_q     <= rd_valid_d;
            wr_valid_q     <= wr_valid_d;
            save_done_q    <= save_done_d;
            restore_done_q <= restore_done_d;
            xfer_error_q   <= xfer_error_d;
            busy_q         <= busy_d;
        end
    end

    // Pointers double as the bus addresses; they only move after a completed write.
    always_comb begin
        mem.rd_valid  = rd_valid_q;
        mem.rd_addr   = src_ptr_q;
        mem.wr_valid  = wr_valid_q;
        mem.wr_addr   = dst_ptr_q;
        mem.wr_data   = data_q;
        save_done     = save_done_q;
        restore_done  = restore_done_q;
        xfer_error    = xfer_error_q;
        busy          = busy_q;
        xfer_checksum = checksum_q;
    end
endmodule

// File: tb/tb_checkpoint_mem_engine.sv
// Directed bench: a small memory responder, a read/write scoreboard and pulse monitors.
`timescale 1ns/1ps
module tb_checkpoint_mem_engine;
    localparam int DW       = 64;
    localparam int TO       = 16;
    localparam int RESP_LAT = 2;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] live_base_addr;
    logic        save_req;
    logic        restore_req;
    logic [63:0] save_addr;
    logic [63:0] restore_addr;
    logic [31:0] transfer_size;
    logic        save_done;
    logic        restore_done;
    logic        xfer_error;
    logic        busy;
    logic [31:0] xfer_checksum;

    checkpoint_mem_engine_if #(.DATA_WIDTH(DW)) mem_if ();

    checkpoint_mem_engine #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .live_base_addr(live_base_addr),
        .save_req      (save_req),
        .restore_req   (restore_req),
        .save_addr     (save_addr),
        .restore_addr  (restore_addr),
        .transfer_size (transfer_size),
        .save_done     (save_done),
        .restore_done  (restore_done),
        .xfer_error    (xfer_error),
        .busy          (busy),
        .xfer_checksum (xfer_checksum),
        .mem           (mem_if)
    );

    always #5 clk = ~clk;

    int tests_run        = 0;
    int tests_failed     = 0;
    int save_done_cnt    = 0;
    int restore_done_cnt = 0;
    int error_cnt        = 0;
    int rd_valid_cycles  = 0;
    int wr_hs_cnt        = 0;

    logic [63:0] rd_exp_q[$];
    wr_exp_t     wr_exp_q[$];
    logic [63:0] err_addr = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_F00D, ~a[31:0] + 32'h9ABC_0101};
    endfunction

    function automatic logic [31:0] word_sum(input logic [63:0] w);
        return w[31:0] + w[63:32];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sreq, input logic rreq, input logic [63:0] live,
                                 input logic [63:0] sa, input logic [63:0] ra, input logic [31:0] size);
        live_base_addr = live;
        save_addr      = sa;
        restore_addr   = ra;
        transfer_size  = size;
        save_req       = sreq;
        restore_req    = rreq;
    endtask

    // Queue the reads and writes a clean transfer should make; returns its checksum.
    task automatic expectTransfer(input logic [63:0] src, input logic [63:0] dst, input int n_words,
                                  output logic [31:0] ck);
        wr_exp_t e;
        ck = '0;
        for (int i = 0; i < n_words; i++) begin
            rd_exp_q.push_back(src + 64'(i * 8));
            e.addr = dst + 64'(i * 8);
            e.data = mem_word(src + 64'(i * 8));
            wr_exp_q.push_back(e);
            ck = ck + word_sum(e.data);
        end
    endtask

    function automatic int event_count(input int kind);
        case (kind)
            0:       return save_done_cnt;
            1:       return restore_done_cnt;
            default: return error_cnt;
        endcase
    endfunction

    task automatic waitForEvent(input int kind, input int target, input int budget);
        for (int i = 0; i < budget && event_count(kind) < target; i++) tick(1);
    endtask

    // Pulse counters and write scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (save_done)       save_done_cnt++;
            if (restore_done)    restore_done_cnt++;
            if (xfer_error)      error_cnt++;
            if (mem_if.rd_valid) rd_valid_cycles++;
            if (mem_if.wr_valid && mem_if.wr_ready) begin
                wr_exp_t e;
                wr_hs_cnt++;
                checkOutput("wr_pending", 64'(wr_exp_q.size() > 0), 64'd1);
                if (wr_exp_q.size() > 0) begin
                    e = wr_exp_q.pop_front();
                    checkOutput("wr_addr", mem_if.wr_addr, e.addr);
                    checkOutput("wr_data", mem_if.wr_data, e.data);
                end
            end
        end
    end

    // Memory read responder with fixed latency and optional error on one address.
    initial begin
        logic [63:0] a;
        mem_if.rd_resp_valid = 1'b0;
        mem_if.rd_resp_data  = '0;
        mem_if.rd_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_if.rd_valid && mem_if.rd_ready) begin
                a = mem_if.rd_addr;
                checkOutput("rd_pending", 64'(rd_exp_q.size() > 0), 64'd1);
                if (rd_exp_q.size() > 0) checkOutput("rd_addr", a, rd_exp_q.pop_front());
                @(posedge clk);
                repeat (RESP_LAT - 1) @(posedge clk);
                #1;
                mem_if.rd_resp_valid = 1'b1;
                mem_if.rd_resp_data  = mem_word(a);
                mem_if.rd_resp_err   = (a == err_addr);
                @(posedge clk);
                #1;
                mem_if.rd_resp_valid = 1'b0;
                mem_if.rd_resp_data  = '0;
                mem_if.rd_resp_err   = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [31:0] ck;
        int sd0, rd0, ec0, wh0, rv0, k;

        rst_n            = 1'b0;
        mem_if.rd_ready  = 1'b1;
        mem_if.wr_ready  = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 32'd0);

        // Reset state
        tick(3);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_rd_valid", 64'(mem_if.rd_valid), 64'd0);
        checkOutput("rst_wr_valid", 64'(mem_if.wr_valid), 64'd0);
        checkOutput("rst_pulses", 64'({save_done, restore_done, xfer_error}), 64'd0);
        checkOutput("rst_checksum", 64'(xfer_checksum), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Save of 16 bytes
        sd0 = save_done_cnt; rd0 = restore_done_cnt; ec0 = error_cnt;
        expectTransfer(64'h1000, 64'h8000, 2, ck);
        applyStimulus(1'b1, 1'b0, 64'h1000, 64'h8000, 64'h0, 32'd16);
        waitForEvent(0, sd0 + 1, 200);
        tick(3);
        checkOutput("save_done_cnt", 64'(save_done_cnt - sd0), 64'd1);
        checkOutput("save_no_restore", 64'(restore_done_cnt - rd0), 64'd0);
        checkOutput("save_no_error", 64'(error_cnt - ec0), 64'd0);
        checkOutput("save_checksum", 64'(xfer_checksum), 64'(ck));
        checkOutput("save_rdq_empty", 64'(rd_exp_q.size()), 64'd0);
        checkOutput("save_wrq_empty", 64'(wr_exp_q.size()), 64'd0);
        checkOutput("save_hold_busy", 64'(busy), 64'd1);
        save_req = 1'b0;
        tick(1);
        checkOutput("save_idle_busy", 64'(busy), 64'd0);
        checkOutput("save_checksum_held", 64'(xfer_checksum), 64'(ck));

        // Restore of 9 bytes (two words)
        sd0 = save_done_cnt; rd0 = restore_done_cnt;
        expectTransfer(64'h8000, 64'h1000, 2, ck);
        applyStimulus(1'b0, 1'b1, 64'h1000, 64'h0, 64'h8000, 32'd9);
        waitForEvent(1, rd0 + 1, 200);
        tick(3);
        checkOutput("restore_done_cnt", 64'(restore_done_cnt - rd0), 64'd1);
        checkOutput("restore_no_save", 64'(save_done_cnt - sd0), 64'd0);
        checkOutput("restore_checksum", 64'(xfer_checksum), 64'(ck));
        checkOutput("restore_wrq_empty", 64'(wr_exp_q.size()), 64'd0);
        restore_req = 1'b0;
        tick(1);

        // Size 0: done the cycle after the request is sampled, no traffic
        rv0 = rd_valid_cycles; wh0 = wr_hs_cnt;
        applyStimulus(1'b1, 1'b0, 64'h1000, 64'h8000, 64'h0, 32'd0);
        tick(1);
        checkOutput("size0_done_now", 64'(save_done), 64'd1);
        checkOutput("size0_busy", 64'(busy), 64'd1);
        tick(1);
        checkOutput("size0_done_pulse_end", 64'(save_done), 64'd0);
        checkOutput("size0_checksum", 64'(xfer_checksum), 64'd0);
        save_req = 1'b0;
        tick(1);
        checkOutput("size0_idle", 64'(busy), 64'd0);
        checkOutput("size0_no_reads", 64'(rd_valid_cycles - rv0), 64'd0);
        checkOutput("size0_no_writes", 64'(wr_hs_cnt - wh0), 64'd0);

        // Read error on word 1 of a 4-word save
        sd0 = save_done_cnt; ec0 = error_cnt; wh0 = wr_hs_cnt;
        err_addr = 64'h2008;
        expectTransfer(64'h2000, 64'h9000, 1, ck);
        rd_exp_q.push_back(64'h2008);
        applyStimulus(1'b1, 1'b0, 64'h2000, 64'h9000, 64'h0, 32'd32);
        waitForEvent(2, ec0 + 1, 200);
        tick(5);
        checkOutput("err_pulse_cnt", 64'(error_cnt - ec0), 64'd1);
        checkOutput("err_no_done", 64'(save_done_cnt - sd0), 64'd0);
        checkOutput("err_one_write", 64'(wr_hs_cnt - wh0), 64'd1);
        checkOutput("err_rdq_empty", 64'(rd_exp_q.size()), 64'd0);
        checkOutput("err_checksum", 64'(xfer_checksum), 64'(ck));
        checkOutput("err_busy_held", 64'(busy), 64'd1);
        save_req = 1'b0;
        err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1);
        checkOutput("err_idle", 64'(busy), 64'd0);

        // Timeout with rd_ready stuck low
        mem_if.rd_ready = 1'b0;
        ec0 = error_cnt;
        applyStimulus(1'b1, 1'b0, 64'h3000, 64'hA000, 64'h0, 32'd8);
        tick(1);
        checkOutput("to_rd_valid_rise", 64'(mem_if.rd_valid), 64'd1);
        checkOutput("to_rd_addr", mem_if.rd_addr, 64'h3000);
        k = 0;
        while (k < 100 && xfer_error !== 1'b1) begin
            tick(1);
            k++;
        end
        checkOutput("to_cycles", 64'(k), 64'(TO));
        checkOutput("to_rd_valid_drop", 64'(mem_if.rd_valid), 64'd0);
        mem_if.rd_ready = 1'b1;
        save_req = 1'b0;
        tick(2);
        checkOutput("to_err_cnt", 64'(error_cnt - ec0), 64'd1);
        checkOutput("to_idle", 64'(busy), 64'd0);

        // Both requests: save wins, held requests do not restart
        sd0 = save_done_cnt; rd0 = restore_done_cnt;
        expectTransfer(64'h4000, 64'hB000, 3, ck);
        applyStimulus(1'b1, 1'b1, 64'h4000, 64'hB000, 64'hC000, 32'd24);
        waitForEvent(0, sd0 + 1, 200);
        rv0 = rd_valid_cycles;
        tick(20);
        checkOutput("both_save_once", 64'(save_done_cnt - sd0), 64'd1);
        checkOutput("both_no_restore", 64'(restore_done_cnt - rd0), 64'd0);
        checkOutput("both_no_restart", 64'(rd_valid_cycles - rv0), 64'd0);
        checkOutput("both_checksum", 64'(xfer_checksum), 64'(ck));
        checkOutput("both_busy_held", 64'(busy), 64'd1);
        save_req = 1'b0;
        tick(1);
        checkOutput("both_restore_still_high", 64'(busy), 64'd1);
        restore_req = 1'b0;
        tick(1);
        checkOutput("both_idle", 64'(busy), 64'd0);

        // Reset in the middle of an 8-word save
        sd0 = save_done_cnt; wh0 = wr_hs_cnt;
        expectTransfer(64'h5000, 64'hD000, 8, ck);
        applyStimulus(1'b1, 1'b0, 64'h5000, 64'hD000, 64'h0, 32'd64);
        for (int i = 0; i < 200 && (wr_hs_cnt - wh0) < 2; i++) tick(1);
        checkOutput("mid_progress", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_valids", 64'({mem_if.rd_valid, mem_if.wr_valid}), 64'd0);
        checkOutput("mid_rst_addrs", mem_if.rd_addr | mem_if.wr_addr, 64'd0);
        checkOutput("mid_rst_wr_data", mem_if.wr_data, 64'd0);
        checkOutput("mid_rst_checksum", 64'(xfer_checksum), 64'd0);
        checkOutput("mid_rst_pulses", 64'({save_done, restore_done, xfer_error}), 64'd0);
        rd_exp_q.delete();
        wr_exp_q.delete();
        save_req = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(3);
        checkOutput("mid_no_done", 64'(save_done_cnt - sd0), 64'd0);
        checkOutput("mid_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/checkpoint_mem_engine.md
# checkpoint_mem_engine

Memory-side responder for the checkpoint controller's memory save/restore requests. On a save request it copies a checkpoint-sized region from the live working buffer to the checkpoint backing address. On a restore request it copies in the other direction. It issues word reads and writes on a simple valid/ready memory port and signals completion with one-cycle done pulses. It also produces a per-transfer checksum and reports error/timeout back to the controller's error inputs.

## Interface
- DATA_WIDTH, 64: memory word width in bits (8 bytes per word)
- TIMEOUT_CYCLES, 1024: maximum cycles without a handshake before the engine declares an error

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- live_base_addr  in  64  base of the live working region
- save_req  in  1  level request: copy live region to save_addr
- restore_req  in  1  level request: copy restore_addr region to live region
- save_addr  in  64  checkpoint destination for a save
- restore_addr  in  64  checkpoint source for a restore
- transfer_size  in  32  size in bytes
- save_done  out  1  one-cycle pulse, save finished
- restore_done  out  1  one-cycle pulse, restore finished
- xfer_error  out  1  one-cycle pulse on read error or timeout
- busy  out  1  high outside IDLE
- xfer_checksum  out  32  running checksum of the current or last transfer
- rd_valid / rd_ready  out / in  1  read request handshake
- rd_addr  out  64  read word address
- rd_resp_valid  in  1  read data return
- rd_resp_data  in  DATA_WIDTH  read data
- rd_resp_err  in  1  read error, qualified by rd_resp_valid
- wr_valid / wr_ready  out / in  1  write handshake (posted writes)
- wr_addr  out  64  write word address
- wr_data  out  DATA_WIDTH  write data

## Operation
- **Reset:** every output is 0 and the FSM is in IDLE.
- **Word count:** words = (transfer_size + 7) >> 3, computed with a 33-bit add, so the count is 30 bits. Bits [2:0] of all addresses are forced to 0.
- **Address generation:** word i uses address base + (i << 3), modulo 2^64.
- **IDLE:**
  - If save_req: latch src = live_base_addr, dst = save_addr, dir = SAVE.
  - Else if restore_req: latch src = restore_addr, dst = live_base_addr, dir = RESTORE.
  - Save has priority when both requests are high.
  - On either request, clear idx and checksum, then go to DONE if words == 0, else to RD_REQ.
- **RD_REQ:** rd_valid = 1. On rd_ready, go to RD_WAIT.
- **RD_WAIT:** on rd_resp_valid:
  - If rd_resp_err, go to ERR.
  - Otherwise capture the data, add checksum += data[31:0] + data[63:32] (mod 2^32), and go to WR.
- **WR:** wr_valid = 1, wr_data = captured word. On wr_ready:
  - Increment idx.
  - If idx + 1 == words, go to DONE.
  - Else if the active request is low (abort), go to IDLE with no done pulse.
  - Else go to RD_REQ.
- **DONE:** pulse save_done or restore_done according to dir, then go to HOLD.
- **ERR:** pulse xfer_error, then go to HOLD. No write is issued for the failed word.
- **HOLD:** wait until save_req and restore_req are both low, then go to IDLE. This stops a request still held high after done from starting a second transfer.
- **Handshake stability:** rd_valid, wr_valid, addresses and data stay stable until accepted. Abort is checked only at word boundaries.
- **Watchdog:** counts cycles in RD_REQ, RD_WAIT and WR. It clears on every rd/rd_resp/wr handshake. Reaching TIMEOUT_CYCLES forces ERR.
- **Checksum output:** xfer_checksum holds its value after DONE or ERR until the next transfer starts.
- **Reset mid-transfer:** the transfer is abandoned immediately, with no done or error pulse.

## Timing
- A request sampled in IDLE at edge N sets busy from N+1.
- Per word, with zero-wait memory: RD_REQ 1 cycle + response at earliest 1 cycle later + WR 1 cycle, i.e. 3 cycles per word minimum.
- The done pulse is high for the one cycle after the final wr handshake edge.
- For size 0, done is high in cycle N+1 and there is no memory traffic.
- xfer_error is high for the one cycle after the edge that detected the error or timeout.
- The done and error pulses are registered outputs.

## Structure
- Shared package checkpoint_pkg holds:
  - the engine state enum (IDLE, RD_REQ, RD_WAIT, WR, DONE, ERR, HOLD)
  - the dir enum (SAVE, RESTORE)
  - BYTES_PER_WORD = 8
- One sub-module, ckpt_xfer_watchdog: cycle counter with clear and enable inputs and a timeout output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Save, size = 16, live_base = 0x1000, save_addr = 0x8000, ready tied 1, response latency 2:
  - reads 0x1000 then 0x1008; writes 0x8000 then 0x8008 with matching data
  - one save_done pulse; checksum equals the sum of the four 32-bit halves
- Restore, size = 9, restore_addr = 0x8000:
  - 2 words read from 0x8000 and 0x8008, written to 0x1000 and 0x1008
  - one restore_done pulse; save_done stays 0
- Size 0 save: save_done high in cycle N+1, rd_valid and wr_valid never asserted, busy drops after the request is released.
- rd_resp_err on word 1 of a 4-word save:
  - one xfer_error pulse; only word 0 is written; no done pulse
  - engine stays busy until save_req drops
- rd_ready held 0 with TIMEOUT_CYCLES = 16: xfer_error fires 16 cycles after rd_valid rises; rd_valid then deasserts.
- save_req and restore_req asserted together, then held high for 20 cycles after done:
  - the save executes and exactly one save_done pulse occurs
  - no second transfer starts until both requests drop
  - assert rst_n mid-transfer: all outputs return to 0
